// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux162 scan controller.
// The state enum, sizes and a helper that picks the first state of a fresh scan.
package mux_scan_pkg;

  localparam int SEL_W = 4;
  localparam int N_CH  = 1 << SEL_W;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_PUBLISH
  } state_e;

  // State entered after choosing a channel: settle first unless the
  // settle time is zero; an empty channel set goes straight to publish.
  function automatic state_e entry_state(input logic found, input logic no_settle);
    if (!found) begin
      return ST_PUBLISH;
    end
    return no_settle ? ST_SAMPLE : ST_SETTLE;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Command, mux and result signals of the scan controller.
// The slave modport is the controller's view; master is the host/mux side.
interface mux_scan_ctrl_if;
  import mux_scan_pkg::*;

  logic              start;
  logic              continuous;
  logic [N_CH-1:0]   ch_mask;
  logic [SEL_W-1:0]  sel;
  logic              mux_in;
  logic              busy;
  logic [N_CH-1:0]   scan_word;
  logic              word_valid;
  logic              word_ready;
  logic              overflow;
  logic              clr_ovf;

  modport slave (
    input  start,
    input  continuous,
    input  ch_mask,
    input  mux_in,
    input  word_ready,
    input  clr_ovf,
    output sel,
    output busy,
    output scan_word,
    output word_valid,
    output overflow
  );

  modport master (
    output start,
    output continuous,
    output ch_mask,
    output mux_in,
    output word_ready,
    output clr_ovf,
    input  sel,
    input  busy,
    input  scan_word,
    input  word_valid,
    input  overflow
  );

endinterface

// File: rtl/mux_scan_next_ch.sv
// Combinational priority finder: lowest enabled channel, either overall
// (first=1) or strictly above the current index (first=0, no wrap).
module mux_scan_next_ch
  import mux_scan_pkg::*;
(
  input  logic [N_CH-1:0]  mask_q,
  input  logic [SEL_W-1:0] cur,
  input  logic             first,
  output logic [SEL_W-1:0] next_idx,
  output logic             found
);

  logic [N_CH-1:0] eligible;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_elig
    localparam logic [SEL_W-1:0] IDX = SEL_W'(gi);
    assign eligible[gi] = mask_q[gi] & (first | (IDX > cur));
  end

  // Scan from the top so the lowest eligible index is the last one written.
  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        next_idx = SEL_W'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller for the 16:1 bit mux: steps sel over enabled channels,
// samples after a settle delay and publishes a snapshot word over valid/ready.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input logic            clk,
  input logic            rst_n,
  mux_scan_ctrl_if.slave bus
);

  localparam logic             NO_SETTLE   = (SETTLE == 0);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_e           state_q,      state_d;
  logic [SEL_W-1:0] sel_q,        sel_d;
  logic [N_CH-1:0]  mask_q,       mask_d;
  logic [N_CH-1:0]  shadow_q,     shadow_d;
  logic [N_CH-1:0]  scan_word_q,  scan_word_d;
  logic             word_valid_q, word_valid_d;
  logic             overflow_q,   overflow_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;

  logic             scan_entry;
  logic [N_CH-1:0]  find_mask;
  logic [SEL_W-1:0] next_idx;
  logic             found;
  logic             launch;
  logic             handshake;
  logic             ovf_set;

  // IDLE and PUBLISH may begin a scan, so they search the live ch_mask
  // from channel 0; mid-scan searches use the latched mask above sel.
  assign scan_entry = (state_q == ST_IDLE) || (state_q == ST_PUBLISH);
  assign find_mask  = scan_entry ? bus.ch_mask : mask_q;

  mux_scan_next_ch u_next_ch (
    .mask_q   (find_mask),
    .cur      (sel_q),
    .first    (scan_entry),
    .next_idx (next_idx),
    .found    (found)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    mask_d       = mask_q;
    shadow_d     = shadow_q;
    scan_word_d  = scan_word_q;
    cnt_d        = cnt_q;
    launch       = 1'b0;
    ovf_set      = 1'b0;
    handshake    = word_valid_q & bus.word_ready;
    word_valid_d = word_valid_q & ~handshake;

    case (state_q)
      ST_IDLE: begin
        launch = bus.start;
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        shadow_d[sel_q] = bus.mux_in;
        state_d         = entry_state(found, NO_SETTLE);
        if (found) begin
          sel_d = next_idx;
        end
      end
      ST_PUBLISH: begin
        scan_word_d  = shadow_q;
        word_valid_d = 1'b1;
        // A handshake on this same edge retires the old word first.
        ovf_set      = word_valid_q & ~bus.word_ready;
        launch       = bus.continuous;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (launch) begin
      mask_d   = bus.ch_mask;
      shadow_d = '0;
      cnt_d    = '0;
      state_d  = entry_state(found, NO_SETTLE);
      if (found) begin
        sel_d = next_idx;
      end
    end

    overflow_d = bus.clr_ovf ? 1'b0 : (overflow_q | ovf_set);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      mask_q       <= '0;
      shadow_q     <= '0;
      scan_word_q  <= '0;
      word_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      mask_q       <= mask_d;
      shadow_q     <= shadow_d;
      scan_word_q  <= scan_word_d;
      word_valid_q <= word_valid_d;
      overflow_q   <= overflow_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.scan_word  = scan_word_q;
  assign bus.word_valid = word_valid_q;
  assign bus.overflow   = overflow_q;

  // Only enabled channels are ever sampled.
  a_sample_enabled : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_SAMPLE) |-> mask_q[sel_q]);

  // An unconsumed word holds still unless a new one is published over it.
  a_word_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (word_valid_q && !bus.word_ready && state_q != ST_PUBLISH)
      |=> (word_valid_q && $stable(scan_word_q)));

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: vector table, random scans against a
// mask/data reference model, and hand sequences for continuous, overflow and reset.
module tb_mux_scan_ctrl;

  localparam int SETTLE = 1;
  localparam int STEP   = SETTLE + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_scan_ctrl_if bus_if ();

  // Behavioural stand-in for mux162: data_out = data_in[sel].
  logic [15:0] mux_data = 16'h0000;
  assign bus_if.mux_in = mux_data[bus_if.sel];

  mux_scan_ctrl #(.SETTLE(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [15:0] mask;
    logic [15:0] data;
    logic [15:0] exp_word;
    int          exp_lat;
    logic [3:0]  exp_sel;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each enabled channel contributes its mux data bit.
  function automatic logic [15:0] model_word(input logic [15:0] m, input logic [15:0] d);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) w[i] = d[i];
    end
    return w;
  endfunction

  function automatic int model_lat(input logic [15:0] m);
    return $countones(m) * STEP + 1;
  endfunction

  function automatic logic [3:0] model_sel_end(input logic [15:0] m);
    int r;
    r = 0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) r = i;
    end
    return 4'(r);
  endfunction

  // One complete scan: start, watch sel, measure latency, check the word, consume it.
  task automatic run_scan(input string name, input logic [15:0] m, input logic [15:0] d,
                          input logic [15:0] exp_word, input int exp_lat,
                          input logic [3:0] exp_sel, input bit disturb);
    int n;
    int bad;
    int q_sel[$];
    int exp_seq[$];
    mux_data       = d;
    bus_if.ch_mask = m;
    bus_if.start   = 1'b1;
    tick();
    bus_if.start = 1'b0;
    check($sformatf("%s_busy_start", name), 32'(bus_if.busy), 32'd1);
    n = 0;
    while (!bus_if.word_valid && n < 200) begin
      q_sel.push_back(int'(bus_if.sel));
      if (disturb && n == 2) begin
        bus_if.ch_mask = ~m;
        bus_if.start   = 1'b1;
      end
      tick();
      bus_if.start = 1'b0;
      n++;
    end
    check($sformatf("%s_latency", name), 32'(n), 32'(exp_lat));
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        for (int k = 0; k < STEP; k++) exp_seq.push_back(i);
      end
    end
    if (m != 16'h0000) begin
      bad = 0;
      if (q_sel.size() < exp_seq.size()) begin
        bad = exp_seq.size();
      end else begin
        for (int i = 0; i < exp_seq.size(); i++) begin
          if (q_sel[i] != exp_seq[i]) bad++;
        end
      end
      check($sformatf("%s_sel_seq_errs", name), 32'(bad), 32'd0);
    end
    check($sformatf("%s_word", name), 32'(bus_if.scan_word), 32'(exp_word));
    check($sformatf("%s_busy_end", name), 32'(bus_if.busy), 32'd0);
    check($sformatf("%s_sel_end", name), 32'(bus_if.sel), 32'(exp_sel));
    check($sformatf("%s_ovf", name), 32'(bus_if.overflow), 32'd0);
    bus_if.word_ready = 1'b1;
    tick();
    bus_if.word_ready = 1'b0;
    check($sformatf("%s_valid_drop", name), 32'(bus_if.word_valid), 32'd0);
    check($sformatf("%s_word_hold", name), 32'(bus_if.scan_word), 32'(exp_word));
    $display("TXN %s mask=%h data=%h word=%h lat=%0d", name, m, d, bus_if.scan_word, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [15:0] m;
    logic [15:0] d;

    vecs[0] = '{"zero_mask", 16'h0000, 16'hFFFF, 16'h0000,  1, 4'd0};
    vecs[1] = '{"all16",     16'hFFFF, 16'hA5C3, 16'hA5C3, 33, 4'd15};
    vecs[2] = '{"ends",      16'h8001, 16'hFFFF, 16'h8001,  5, 4'd15};
    vecs[3] = '{"evens",     16'h5555, 16'h0F0F, 16'h0505, 17, 4'd14};
    vecs[4] = '{"top_only",  16'h8000, 16'h8000, 16'h8000,  3, 4'd15};
    vecs[5] = '{"ch0_zero",  16'h0001, 16'hFFFE, 16'h0000,  3, 4'd0};

    bus_if.start      = 1'b0;
    bus_if.continuous = 1'b0;
    bus_if.ch_mask    = 16'h0000;
    bus_if.word_ready = 1'b0;
    bus_if.clr_ovf    = 1'b0;

    #12;
    check("rst_sel",        32'(bus_if.sel),        32'd0);
    check("rst_busy",       32'(bus_if.busy),       32'd0);
    check("rst_scan_word",  32'(bus_if.scan_word),  32'd0);
    check("rst_word_valid", 32'(bus_if.word_valid), 32'd0);
    check("rst_overflow",   32'(bus_if.overflow),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_scan(vecs[i].name, vecs[i].mask, vecs[i].data, vecs[i].exp_word,
               vecs[i].exp_lat, vecs[i].exp_sel, 1'b0);
    end

    for (int i = 0; i < 20; i++) begin
      m = 16'($urandom) & 16'($urandom);
      if (m == 16'h0000) m = 16'h0100;
      d = 16'($urandom);
      run_scan("rnd", m, d, model_word(m, d), model_lat(m), model_sel_end(m), 1'b0);
    end

    // Continuous scanning with nobody consuming: second word overflows.
    mux_data          = 16'hFFFD;
    bus_if.ch_mask    = 16'h0003;
    bus_if.continuous = 1'b1;
    bus_if.start      = 1'b1;
    tick();
    bus_if.start = 1'b0;
    n = 0;
    while (!bus_if.word_valid && n < 200) begin tick(); n++; end
    check("cont_lat1",  32'(n),                 32'd5);
    check("cont_word1", 32'(bus_if.scan_word),  32'h0001);
    check("cont_ovf1",  32'(bus_if.overflow),   32'd0);
    check("cont_busy1", 32'(bus_if.busy),       32'd1);
    mux_data          = 16'hFFFE;
    bus_if.continuous = 1'b0;
    n = 0;
    while (!bus_if.overflow && n < 200) begin tick(); n++; end
    check("cont_lat2",   32'(n),                 32'd5);
    check("cont_ovf2",   32'(bus_if.overflow),   32'd1);
    check("cont_word2",  32'(bus_if.scan_word),  32'h0002);
    check("cont_valid2", 32'(bus_if.word_valid), 32'd1);
    check("cont_busy2",  32'(bus_if.busy),       32'd0);
    bus_if.clr_ovf = 1'b1;
    tick();
    bus_if.clr_ovf = 1'b0;
    check("clr_ovf",       32'(bus_if.overflow),   32'd0);
    check("clr_ovf_valid", 32'(bus_if.word_valid), 32'd1);
    bus_if.word_ready = 1'b1;
    tick();
    bus_if.word_ready = 1'b0;
    check("cont_consume", 32'(bus_if.word_valid), 32'd0);
    $display("TXN continuous mask=0003 words=0001,0002 overflow_seen");

    // Handshake on the very edge of the second publish: no overflow.
    mux_data          = 16'h0001;
    bus_if.ch_mask    = 16'h0001;
    bus_if.continuous = 1'b1;
    bus_if.start      = 1'b1;
    tick();
    bus_if.start = 1'b0;
    n = 0;
    while (!bus_if.word_valid && n < 200) begin tick(); n++; end
    check("hs_lat1",  32'(n),                32'd3);
    check("hs_word1", 32'(bus_if.scan_word), 32'h0001);
    mux_data          = 16'h0000;
    bus_if.continuous = 1'b0;
    tick();
    tick();
    bus_if.word_ready = 1'b1;
    tick();
    bus_if.word_ready = 1'b0;
    check("hs_valid2", 32'(bus_if.word_valid), 32'd1);
    check("hs_ovf2",   32'(bus_if.overflow),   32'd0);
    check("hs_word2",  32'(bus_if.scan_word),  32'h0000);
    bus_if.word_ready = 1'b1;
    tick();
    bus_if.word_ready = 1'b0;
    check("hs_consume", 32'(bus_if.word_valid), 32'd0);
    $display("TXN handshake_at_publish mask=0001 words=0001,0000");

    // Mid-scan start and mask changes are ignored.
    run_scan("ignore", 16'h00F0, 16'hFFFF, 16'h00F0, 9, 4'd7, 1'b1);

    // Asynchronous reset mid-scan, then a fresh scan.
    mux_data       = 16'hA5C3;
    bus_if.ch_mask = 16'hFFFF;
    bus_if.start   = 1'b1;
    tick();
    bus_if.start = 1'b0;
    n = 0;
    while (bus_if.sel != 4'd7 && n < 100) begin tick(); n++; end
    check("rst_mid_reach_sel7", 32'(bus_if.sel), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_sel",        32'(bus_if.sel),        32'd0);
    check("rst_mid_busy",       32'(bus_if.busy),       32'd0);
    check("rst_mid_word_valid", 32'(bus_if.word_valid), 32'd0);
    check("rst_mid_scan_word",  32'(bus_if.scan_word),  32'd0);
    check("rst_mid_overflow",   32'(bus_if.overflow),   32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    check("rst_mid_no_publish", 32'(bus_if.word_valid), 32'd0);
    check("rst_mid_idle",       32'(bus_if.busy),       32'd0);
    $display("TXN reset_mid_scan aborted at sel=7");
    run_scan("after_rst", 16'hFFFF, 16'hA5C3, 16'hA5C3, 33, 4'd15, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
